trap_peak_detector: RTL and testbench
=====================================

Name: trap_peak_detector

Overview:
- Sits directly downstream of the trapezoidal shaping filter and consumes its 16-bit signed output stream, one sample per clock.
- Detects pulses crossing a programmable threshold and tracks the maximum (flat-top) amplitude of each pulse.
- Emits one event per pulse: amplitude, peak timestamp and pulse width, through a 1-deep valid/ready output register.
- Counts events lost to output back-pressure.

Parameters:
- DATA_W, 16, sample and amplitude width (signed).
- TS_W, 32, timestamp counter width.
- WID_W, 8, pulse-width field width.
- HOLDOFF, 16, cycles ignored after each pulse ends (pile-up/undershoot guard).
- LOST_W, 16, lost-event counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low.
- in_data, in, DATA_W, signed filtered sample, valid every cycle.
- threshold, in, DATA_W, signed trigger level; sampled only in IDLE.
- out_valid, out, 1, event register holds an unread event.
- out_ready, in, 1, consumer accepts the event when out_valid is also high.
- out_amp, out, DATA_W, signed peak amplitude.
- out_ts, out, TS_W, timestamp of the first sample equal to the peak value.
- out_width, out, WID_W, number of samples above threshold, saturating.
- lost_cnt, out, LOST_W, events dropped, saturating.
- busy, out, 1, FSM not in IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - ts counter, out_valid, out_amp, out_ts, out_width, lost_cnt, busy and internal max/width/holdoff registers all go to 0.
  - Reset mid-pulse discards the pulse; no event is emitted.
- Timestamp: ts increments every clock out of reset and wraps modulo 2^TS_W with no flag.
- All comparisons are signed, DATA_W bits.
- IDLE:
  - If in_data > threshold (strict): latch thr_q = threshold, max = in_data, max_ts = ts, width = 1, go to ARMED.
  - Otherwise stay in IDLE.
- ARMED:
  - If in_data > thr_q:
    - width increments, saturating at 2^WID_W-1.
    - If in_data > max (strict), update max and max_ts; equal values keep the earlier timestamp.
  - If in_data <= thr_q: emit the event {max, max_ts, width}, load the holdoff counter with HOLDOFF, go to HOLDOFF.
  - The below-threshold sample itself is not counted in width.
- HOLDOFF:
  - Counter decrements each clock; in_data is ignored.
  - Go to IDLE when the counter reaches 1, so exactly HOLDOFF cycles are spent in HOLDOFF.
  - HOLDOFF=0 means return to IDLE on the next cycle (1 cycle).
- Latency: out_valid rises on the clock edge that samples the first at-or-below-threshold input. The event is visible in the following cycle.
- Output handshake:
  - A transfer occurs on a clock edge where out_valid && out_ready.
  - out_amp, out_ts and out_width stay stable while out_valid=1 and not accepted.
  - Emit with the register empty, or with a transfer in the same edge: the new event loads and out_valid stays or goes to 1.
  - Emit with out_valid=1 and out_ready=0: the new event is dropped and lost_cnt increments, saturating at all-ones. The held event is unchanged.
  - After a transfer with no new emit, out_valid goes to 0. Output fields keep their last values.
- Threshold changes while in ARMED or HOLDOFF have no effect until the next IDLE.
- A sample equal to threshold never triggers.
- busy = (state != IDLE), registered.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then in_data=0, threshold=100 -> all outputs 0, busy=0, no out_valid.
- Single pulse: threshold=100, out_ready=1, samples 50,150,300,300,200,90 starting at ts=10 -> one event with amp=300, ts=12 (first of the equal peaks), width=4, out_valid for 1 cycle.
- Holdoff: HOLDOFF=16, a second pulse arrives 5 cycles after the first ends -> ignored, no event. The same pulse arriving 20 cycles after -> detected.
- Back-pressure: out_ready=0, three separated pulses -> the first event is held unchanged, lost_cnt=2. Then out_ready=1 -> one transfer, out_valid=0.
- Width saturation and boundary: WID_W=8, 300 samples at 1000 with threshold 100 -> width=255. A pulse at exactly 100 -> no trigger. threshold=-50 with samples -10 -> trigger (signed compare).
- Reset mid-pulse: assert reset while ARMED -> no event, lost_cnt=0, state IDLE. A subsequent pulse is detected normally, with ts restarted from 0.

Source files
------------

// File: rtl/trap_peak_detector.sv
// Pulse detector for the trapezoidal filter output.
// Emits one event per pulse carrying its peak amplitude, peak timestamp and width, and counts events dropped under back-pressure.
module trap_peak_detector #(
  parameter int DATA_W  = 16,
  parameter int TS_W    = 32,
  parameter int WID_W   = 8,
  parameter int HOLDOFF = 16,
  parameter int LOST_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_amp,
  output logic [TS_W-1:0]          out_ts,
  output logic [WID_W-1:0]         out_width,
  output logic [LOST_W-1:0]        lost_cnt,
  output logic                     busy
);

  // state | meaning
  // IDLE  | waiting for a sample strictly above threshold
  // ARMED | inside a pulse, tracking max and width
  // HOLD  | post-pulse guard, samples ignored
  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  localparam int HO_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  state_t                   state;
  logic [TS_W-1:0]          ts;
  logic signed [DATA_W-1:0] thr_q;
  logic signed [DATA_W-1:0] max_v;
  logic [TS_W-1:0]          max_ts;
  logic [WID_W-1:0]         width;
  logic [HO_W-1:0]          hold_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ts        <= '0;
      thr_q     <= '0;
      max_v     <= '0;
      max_ts    <= '0;
      width     <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      out_amp   <= '0;
      out_ts    <= '0;
      out_width <= '0;
      lost_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_data > threshold) begin
            thr_q  <= threshold;
            max_v  <= in_data;
            max_ts <= ts;
            width  <= WID_W'(1);
            state  <= ARMED;
            busy   <= 1'b1;
          end
        end

        ARMED: begin
          if (in_data > thr_q) begin
            if (width != '1)
              width <= width + 1'b1;
            // strict compare keeps the earliest of equal peaks
            if (in_data > max_v) begin
              max_v  <= in_data;
              max_ts <= ts;
            end
          end else begin
            if (!out_valid || out_ready) begin
              out_valid <= 1'b1;
              out_amp   <= max_v;
              out_ts    <= max_ts;
              out_width <= width;
            end else if (lost_cnt != '1) begin
              lost_cnt <= lost_cnt + 1'b1;
            end
            hold_cnt <= HO_W'(HOLDOFF);
            state    <= HOLD;
          end
        end

        HOLD: begin
          // a load of 0 or 1 leaves after a single cycle
          if (hold_cnt <= HO_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_peak_detector.sv
// Self-checking bench for trap_peak_detector: directed table, corner sequences and
// randomized runs against an offline pulse-scan reference model.
module tb_trap_peak_detector;

  localparam int H    = 16;
  localparam int N    = 1600;
  localparam int WMAX = 255;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] threshold = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic signed [15:0] out_amp;
  logic [31:0]        out_ts;
  logic [7:0]         out_width;
  logic [15:0]        lost_cnt;
  logic               busy;

  trap_peak_detector dut (
    .clk(clk), .reset(reset), .in_data(in_data), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_amp(out_amp),
    .out_ts(out_ts), .out_width(out_width), .lost_cnt(lost_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcount;

  int s[N];
  int thr[N];
  bit rdy[N];
  bit emit[N];
  bit bsy[N];
  int e_amp[N];
  int e_ts[N];
  int e_w[N];

  typedef struct {
    int din;
    int thr;
    bit rdy;
    bit ev;
    int eamp;
    int ets;
    int ew;
    bit eb;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int t, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; in_data = '0; threshold = 16'sd100; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", -1, out_valid, 0);
    chk("rst_amp",   -1, out_amp, 0);
    chk("rst_ts",    -1, out_ts, 0);
    chk("rst_width", -1, out_width, 0);
    chk("rst_lost",  -1, lost_cnt, 0);
    chk("rst_busy",  -1, busy, 0);
    reset = 1'b1;
  endtask

  task automatic fill(input int n, input int sv, input int tv, input bit rv);
    for (int k = 0; k < n; k++) begin
      s[k] = sv; thr[k] = tv; rdy[k] = rv;
    end
  endtask

  // Scan the whole stimulus for pulses: trigger, extent, peak, then skip the guard window.
  task automatic build_model(input int n);
    int p, j, mx, mts, tq, w, hd;
    hd = (H < 1) ? 1 : H;
    for (int k = 0; k < n; k++) begin
      emit[k] = 1'b0; bsy[k] = 1'b0;
    end
    p = 0;
    while (p < n) begin
      if (s[p] > thr[p]) begin
        tq = thr[p]; mx = s[p]; mts = p; j = p + 1;
        while (j < n && s[j] > tq) begin
          if (s[j] > mx) begin
            mx = s[j]; mts = j;
          end
          j++;
        end
        w = (j - p > WMAX) ? WMAX : j - p;
        for (int k = p; k < j + hd && k < n; k++) bsy[k] = 1'b1;
        if (j < n) begin
          emit[j] = 1'b1; e_amp[j] = mx; e_ts[j] = mts; e_w[j] = w;
        end
        p = j + hd + 1;
      end else begin
        p++;
      end
    end
  endtask

  task automatic run_seq(input int n);
    int v, amp, tsv, wid, lost;
    build_model(n);
    do_reset();
    v = 0; amp = 0; tsv = 0; wid = 0; lost = 0; vcount = 0;
    for (int t = 0; t < n; t++) begin
      in_data = 16'(s[t]); threshold = 16'(thr[t]); out_ready = rdy[t];
      @(negedge clk);
      if (emit[t]) begin
        if (v == 0 || rdy[t]) begin
          v = 1; amp = e_amp[t]; tsv = e_ts[t]; wid = e_w[t];
        end else if (lost < 65535) begin
          lost++;
        end
      end else if (v == 1 && rdy[t]) begin
        v = 0;
      end
      chk("valid", t, out_valid, v);
      chk("busy",  t, busy, bsy[t]);
      chk("lost",  t, lost_cnt, lost);
      chk("amp",   t, out_amp, amp);
      chk("ts",    t, out_ts, tsv);
      chk("width", t, out_width, wid);
      if (out_valid) vcount++;
    end
  endtask

  initial begin
    tbl[0] = '{50,  100, 1'b1, 1'b0, 0,   0,  0, 1'b0};
    tbl[1] = '{150, 100, 1'b1, 1'b0, 0,   0,  0, 1'b1};
    tbl[2] = '{300, 100, 1'b1, 1'b0, 0,   0,  0, 1'b1};
    tbl[3] = '{300, 100, 1'b1, 1'b0, 0,   0,  0, 1'b1};
    tbl[4] = '{200, 100, 1'b1, 1'b0, 0,   0,  0, 1'b1};
    tbl[5] = '{90,  100, 1'b1, 1'b1, 300, 12, 4, 1'b1};
    tbl[6] = '{0,   100, 1'b1, 1'b0, 300, 12, 4, 1'b1};
    tbl[7] = '{0,   100, 1'b1, 1'b0, 300, 12, 4, 1'b1};

    // single pulse, directed table starting at ts=10
    do_reset();
    for (int t = 0; t < 10; t++) begin
      in_data = '0; threshold = 16'sd100; out_ready = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      in_data = 16'(tbl[k].din); threshold = 16'(tbl[k].thr); out_ready = tbl[k].rdy;
      @(negedge clk);
      chk("tbl_valid", 10 + k, out_valid, tbl[k].ev);
      chk("tbl_amp",   10 + k, out_amp, tbl[k].eamp);
      chk("tbl_ts",    10 + k, out_ts, tbl[k].ets);
      chk("tbl_width", 10 + k, out_width, tbl[k].ew);
      chk("tbl_busy",  10 + k, busy, tbl[k].eb);
    end

    // holdoff: pulse 5 cycles after the end is ignored, 20 cycles after is seen
    fill(80, 0, 100, 1'b1);
    for (int k = 20; k < 24; k++) s[k] = 500;
    for (int k = 29; k < 32; k++) s[k] = 500;
    for (int k = 44; k < 47; k++) s[k] = 500;
    run_seq(80);
    chk("hold_events", 80, vcount, 2);
    chk("hold_ts",     80, out_ts, 44);
    chk("hold_width",  80, out_width, 3);

    // back-pressure: first event held, two lost, then drained
    fill(140, 0, 100, 1'b0);
    for (int k = 110; k < 140; k++) rdy[k] = 1'b1;
    for (int k = 10; k < 13; k++) s[k] = 400;
    for (int k = 40; k < 42; k++) s[k] = 600;
    for (int k = 70; k < 73; k++) s[k] = 700;
    run_seq(140);
    chk("bp_lost",  140, lost_cnt, 2);
    chk("bp_valid", 140, out_valid, 0);
    chk("bp_amp",   140, out_amp, 400);
    chk("bp_ts",    140, out_ts, 10);

    // width saturation
    fill(330, 0, 100, 1'b1);
    for (int k = 5; k < 305; k++) s[k] = 1000;
    run_seq(330);
    chk("sat_width", 330, out_width, 255);
    chk("sat_amp",   330, out_amp, 1000);
    chk("sat_ts",    330, out_ts, 5);

    // sample equal to threshold never triggers
    fill(40, 100, 100, 1'b1);
    run_seq(40);
    chk("eq_events", 40, vcount, 0);

    // signed compare with a negative threshold
    fill(40, -100, -50, 1'b1);
    for (int k = 5; k < 8; k++) s[k] = -10;
    run_seq(40);
    chk("neg_events", 40, vcount, 1);
    chk("neg_amp",    40, out_amp, -10);
    chk("neg_width",  40, out_width, 3);
    chk("neg_ts",     40, out_ts, 5);

    // reset while armed, then a clean pulse with ts restarted
    fill(12, 0, 100, 1'b1);
    for (int k = 5; k < 12; k++) s[k] = 500;
    run_seq(12);
    chk("mid_events", 12, vcount, 0);
    chk("mid_busy",   12, busy, 1);
    fill(30, 0, 100, 1'b1);
    s[3] = 200; s[4] = 300; s[5] = 250;
    run_seq(30);
    chk("post_ts",    30, out_ts, 4);
    chk("post_amp",   30, out_amp, 300);
    chk("post_width", 30, out_width, 3);

    // randomized runs with drifting threshold and random back-pressure
    for (int r = 0; r < 3; r++) begin
      int cur;
      cur = 100;
      for (int t = 0; t < N; t++) begin
        if (t % 50 == 0) begin
          if ($urandom_range(0, 1) == 0) cur = (int'($urandom_range(0, 3)) - 1) * 100;
          else cur = int'($urandom_range(0, 400)) - 100;
        end
        thr[t] = cur;
        if (t > 0 && $urandom_range(0, 1) == 1) s[t] = s[t-1];
        else s[t] = (int'($urandom_range(0, 9)) - 3) * 100;
        rdy[t] = ($urandom_range(0, 3) != 0);
      end
      run_seq(N);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
